// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: hazard inputs and pipeline latch controls between core and stall controller
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit_i;
    logic             dhit_i;
    logic             mem_dreq_i;
    logic             mem_halt_i;
    logic             ex_pcsrc_taken_i;
    logic             ex_memtoreg_i;
    logic             ex_regwr_i;
    logic [4:0]       ex_wrdest_i;
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             id_uses_rt_i;
    logic             pc_en_o;
    logic             ifid_en_o;
    logic             idex_en_o;
    logic             exmem_en_o;
    logic             memwb_en_o;
    logic             ifid_flush_o;
    logic             idex_flush_o;
    logic             exmem_flush_o;
    logic             memwb_flush_o;
    logic             halted_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [CNT_W-1:0] flush_count_o;

    modport master (
        output ihit_i, dhit_i, mem_dreq_i, mem_halt_i, ex_pcsrc_taken_i, ex_memtoreg_i,
               ex_regwr_i, ex_wrdest_i, id_rs_i, id_rt_i, id_uses_rt_i,
        input  pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o, ifid_flush_o,
               idex_flush_o, exmem_flush_o, memwb_flush_o, halted_o, stall_cycles_o,
               flush_count_o
    );

    modport slave (
        input  ihit_i, dhit_i, mem_dreq_i, mem_halt_i, ex_pcsrc_taken_i, ex_memtoreg_i,
               ex_regwr_i, ex_wrdest_i, id_rs_i, id_rt_i, id_uses_rt_i,
        output pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o, ifid_flush_o,
               idex_flush_o, exmem_flush_o, memwb_flush_o, halted_o, stall_cycles_o,
               flush_count_o
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: per-cycle latch enables/flushes for load-use, cache-miss, branch and halt
module hazard_stall_ctrl #(
    parameter int LU_STALL = 2,
    parameter int CNT_W    = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_stall_ctrl_if.slave b
);
    typedef enum logic [1:0] {RUN, LDUSE, HALT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       lu_left_q, lu_left_d;
    logic [CNT_W-1:0] stall_q, flush_q;
    logic [4:0]       en;
    logic [3:0]       fl;
    logic             halted, stall_inc, flush_inc, hazard, halt_now, dfreeze;

    assign hazard = b.ex_memtoreg_i && b.ex_regwr_i && (b.ex_wrdest_i != 5'd0) &&
                    ((b.ex_wrdest_i == b.id_rs_i) || (b.id_uses_rt_i && b.ex_wrdest_i == b.id_rt_i));
    assign halt_now = (state_q == HALT) || (b.mem_halt_i && (!b.mem_dreq_i || b.dhit_i));
    assign dfreeze  = b.mem_dreq_i && !b.dhit_i;

    assign {b.pc_en_o, b.ifid_en_o, b.idex_en_o, b.exmem_en_o, b.memwb_en_o} = en;
    assign {b.ifid_flush_o, b.idex_flush_o, b.exmem_flush_o, b.memwb_flush_o} = fl;
    assign b.halted_o       = halted;
    assign b.stall_cycles_o = stall_q;
    assign b.flush_count_o  = flush_q;

    // priority decode: reset, halt, d-miss freeze, branch squash, load-use, i-miss, run
    always_comb begin
        en        = 5'b11111;
        fl        = 4'b0000;
        halted    = 1'b0;
        state_d   = state_q;
        lu_left_d = lu_left_q;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (rst) begin
            en = 5'b00000;
            fl = 4'b1111;
        end else if (halt_now) begin
            en      = 5'b00000;
            halted  = 1'b1;
            state_d = HALT;
        end else if (dfreeze) begin
            en        = 5'b00001;
            fl        = 4'b0001;
            stall_inc = 1'b1;
        end else if (b.ex_pcsrc_taken_i) begin
            fl        = 4'b1100;
            flush_inc = 1'b1;
            state_d   = RUN;
            lu_left_d = 2'd0;
        end else if (state_q == LDUSE || hazard) begin
            en        = 5'b00111;
            fl        = 4'b0100;
            stall_inc = 1'b1;
            if (state_q == LDUSE) begin
                lu_left_d = lu_left_q - 2'd1;
                state_d   = (lu_left_q == 2'd1) ? RUN : LDUSE;
            end else if (LU_STALL > 1) begin
                lu_left_d = 2'(LU_STALL - 1);
                state_d   = LDUSE;
            end
        end else if (!b.ihit_i) begin
            en        = 5'b01111;
            fl        = 4'b1000;
            stall_inc = 1'b1;
        end
    end

    // state, remaining bubbles and saturating statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            lu_left_q <= 2'd0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            lu_left_q <= lu_left_d;
            stall_q   <= (stall_inc && stall_q != '1) ? stall_q + 1'b1 : stall_q;
            flush_q   <= (flush_inc && flush_q != '1) ? flush_q + 1'b1 : flush_q;
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: table-driven directed check of stall/flush control and statistics
module tb_hazard_stall_ctrl;
    localparam logic [9:0] NORM = 10'b11111_0000_0;
    localparam logic [9:0] RSTO = 10'b00000_1111_0;
    localparam logic [9:0] HLT  = 10'b00000_0000_1;
    localparam logic [9:0] DFRZ = 10'b00001_0001_0;
    localparam logic [9:0] BR   = 10'b11111_1100_0;
    localparam logic [9:0] LU   = 10'b00111_0100_0;
    localparam logic [9:0] IM   = 10'b01111_1000_0;
    localparam int NV = 34;

    typedef struct {
        logic [6:0] c;
        logic [4:0] wd, rs, rt;
        logic       urt;
        logic [9:0] exp;
        int         es, ef;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   npass = 0;
    int   ntot  = 0;
    vec_t v[NV];

    hazard_stall_ctrl_if #(.CNT_W(4)) hif();
    hazard_stall_ctrl #(.LU_STALL(2), .CNT_W(4)) dut (.clk(clk), .rst(rst), .b(hif));

    always #5 clk = ~clk;

    logic [9:0] out;
    assign out = {hif.pc_en_o, hif.ifid_en_o, hif.idex_en_o, hif.exmem_en_o, hif.memwb_en_o,
                  hif.ifid_flush_o, hif.idex_flush_o, hif.exmem_flush_o, hif.memwb_flush_o,
                  hif.halted_o};

    function automatic vec_t mk(input logic [6:0] c, input logic [4:0] wd, rs, rt,
                                input logic urt, input logic [9:0] exp, input int es, ef);
        vec_t r;
        r.c = c; r.wd = wd; r.rs = rs; r.rt = rt; r.urt = urt;
        r.exp = exp; r.es = es; r.ef = ef;
        return r;
    endfunction

    task automatic drv(input logic [6:0] c, input logic [4:0] wd, rs, rt, input logic urt);
        {hif.ihit_i, hif.dhit_i, hif.mem_dreq_i, hif.mem_halt_i, hif.ex_pcsrc_taken_i,
         hif.ex_memtoreg_i, hif.ex_regwr_i} = c;
        hif.ex_wrdest_i  = wd;
        hif.id_rs_i      = rs;
        hif.id_rt_i      = rt;
        hif.id_uses_rt_i = urt;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic chk_all(input string tag, input logic [9:0] e, input int es, ef);
        chk({tag, " ctl"}, 32'(out), 32'(e));
        chk({tag, " stall"}, 32'(hif.stall_cycles_o), 32'(es));
        chk({tag, " flush"}, 32'(hif.flush_count_o), 32'(ef));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        v[0]  = mk(7'b1000000, 0, 0, 0, 0, NORM, 0, 0);
        v[1]  = mk(7'b1000011, 2, 2, 0, 0, LU,   0, 0);
        v[2]  = mk(7'b1000000, 0, 0, 0, 0, LU,   1, 0);
        v[3]  = mk(7'b1000000, 0, 0, 0, 0, NORM, 2, 0);
        v[4]  = mk(7'b1000011, 0, 0, 0, 0, NORM, 2, 0);
        v[5]  = mk(7'b1000011, 5, 3, 5, 0, NORM, 2, 0);
        v[6]  = mk(7'b1000011, 5, 3, 5, 1, LU,   2, 0);
        v[7]  = mk(7'b1000000, 0, 0, 0, 0, LU,   3, 0);
        v[8]  = mk(7'b1000010, 4, 4, 0, 0, NORM, 4, 0);
        v[9]  = mk(7'b0000100, 0, 0, 0, 0, BR,   4, 0);
        v[10] = mk(7'b1000000, 0, 0, 0, 0, NORM, 4, 1);
        v[11] = mk(7'b0000000, 0, 0, 0, 0, IM,   4, 1);
        v[12] = mk(7'b1000111, 2, 2, 0, 0, BR,   5, 1);
        v[13] = mk(7'b1000000, 0, 0, 0, 0, NORM, 5, 2);
        v[14] = mk(7'b1010100, 0, 0, 0, 0, DFRZ, 5, 2);
        v[15] = mk(7'b1110000, 0, 0, 0, 0, NORM, 6, 2);
        v[16] = mk(7'b1000011, 2, 2, 0, 0, LU,   6, 2);
        v[17] = mk(7'b1010000, 0, 0, 0, 0, DFRZ, 7, 2);
        v[18] = mk(7'b1010000, 0, 0, 0, 0, DFRZ, 8, 2);
        v[19] = mk(7'b1010000, 0, 0, 0, 0, DFRZ, 9, 2);
        v[20] = mk(7'b1110000, 0, 0, 0, 0, LU,   10, 2);
        v[21] = mk(7'b1000000, 0, 0, 0, 0, NORM, 11, 2);
        v[22] = mk(7'b0000000, 0, 0, 0, 0, IM,   11, 2);
        v[23] = mk(7'b0000000, 0, 0, 0, 0, IM,   12, 2);
        v[24] = mk(7'b0000000, 0, 0, 0, 0, IM,   13, 2);
        v[25] = mk(7'b0000000, 0, 0, 0, 0, IM,   14, 2);
        v[26] = mk(7'b0000000, 0, 0, 0, 0, IM,   15, 2);
        v[27] = mk(7'b0000000, 0, 0, 0, 0, IM,   15, 2);
        v[28] = mk(7'b1000000, 0, 0, 0, 0, NORM, 15, 2);
        v[29] = mk(7'b1011000, 0, 0, 0, 0, DFRZ, 15, 2);
        v[30] = mk(7'b1001000, 0, 0, 0, 0, HLT,  15, 2);
        v[31] = mk(7'b1000000, 0, 0, 0, 0, HLT,  15, 2);
        v[32] = mk(7'b0000100, 0, 0, 0, 0, HLT,  15, 2);
        v[33] = mk(7'b1000000, 0, 0, 0, 0, HLT,  15, 2);

        drv(7'b1000000, 0, 0, 0, 0);
        @(negedge clk);
        chk("reset ctl", 32'(out), 32'(RSTO));
        step();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            drv(v[i].c, v[i].wd, v[i].rs, v[i].rt, v[i].urt);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), v[i].exp, v[i].es, v[i].ef);
            step();
        end

        rst = 1'b1;
        drv(7'b1000000, 0, 0, 0, 0);
        @(negedge clk);
        chk("halt reset ctl", 32'(out), 32'(RSTO));
        step();
        rst = 1'b0;
        @(negedge clk);
        chk_all("after halt reset", NORM, 0, 0);
        step();

        drv(7'b1000011, 7, 7, 0, 0);
        @(negedge clk);
        chk("ldu before reset", 32'(out), 32'(LU));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("ldu reset ctl", 32'(out), 32'(RSTO));
        step();
        rst = 1'b0;
        drv(7'b1000000, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("after ldu reset", NORM, 0, 0);
        step();

        drv(7'b1010000, 0, 0, 0, 0);
        @(negedge clk);
        chk("freeze before reset", 32'(out), 32'(DFRZ));
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("freeze reset ctl", 32'(out), 32'(RSTO));
        step();
        rst = 1'b0;
        drv(7'b1000000, 0, 0, 0, 0);
        @(negedge clk);
        chk_all("after freeze reset", NORM, 0, 0);
        step();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
